// File: rtl/key_event_buffer_pkg.sv
// Shared definitions for the key event buffer: key width, key codes and
// debounce state encodings.
package key_event_buffer_pkg;

    localparam int KEY_W_DEF = 5;

    // Key code reported on key_out when the queue is empty.
    localparam logic [KEY_W_DEF-1:0] KEY_NONE = '0;

    // Debounce FSM states.
    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_PRESS_WAIT   = 2'd1,
        ST_HELD         = 2'd2,
        ST_RELEASE_WAIT = 2'd3
    } deb_state_t;

endpackage

// File: rtl/key_event_buffer_fifo.sv
// Small synchronous FIFO with show-ahead output and a flush port.
// Handshake: dout is the head entry whenever valid=1. pop=1 with valid=1
// consumes the head on that edge. pop while empty is ignored. push while
// full is dropped unless a pop is accepted on the same edge. overflow is
// sticky until flush. All outputs are registered.
module key_event_buffer_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 5
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [W-1:0]               din,
    input  logic                       pop,
    input  logic                       flush,
    output logic [W-1:0]               dout,
    output logic                       valid,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          full;
    logic          empty;
    logic          do_push;
    logic          do_pop;
    logic          drop;
    logic [CW-1:0] count_next;
    logic [W-1:0]  head_next;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign drop    = push && full && !do_pop;

    // Next occupancy and next head value, so the show-ahead output can be registered.
    always_comb begin
        count_next = count;
        head_next  = dout;
        if (do_push && !do_pop) begin
            count_next = count + CW'(1);
        end else if (do_pop && !do_push) begin
            count_next = count - CW'(1);
        end
        if (do_pop) begin
            if (count == CW'(1)) begin
                head_next = do_push ? din : '0;
            end else begin
                head_next = mem[rd_ptr + AW'(1)];
            end
        end else if (do_push && empty) begin
            head_next = din;
        end
    end

    // Storage array; no reset needed since the head is tracked in dout.
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers, occupancy and registered outputs; flush beats push/pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            dout     <= '0;
            valid    <= 1'b0;
            overflow <= 1'b0;
        end else if (flush) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            dout     <= '0;
            valid    <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count    <= count_next;
            dout     <= head_next;
            valid    <= (count_next != '0);
            overflow <= overflow | drop;
        end
    end

endmodule

// File: rtl/key_event_buffer.sv
// Debounces the keypad level pair into one event per physical press and
// queues the events for the game FSM / hero selection.
// Consumer handshake: key_out is valid whenever key_valid=1; pop=1 accepts it.
module key_event_buffer
    import key_event_buffer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int DEPTH           = 4,
    parameter int KEY_W           = KEY_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [KEY_W-1:0]       key,
    input  logic                   keypad_pressed,
    input  logic                   flush,
    input  logic                   pop,
    output logic                   key_valid,
    output logic [KEY_W-1:0]       key_out,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    output deb_state_t             dbg_state
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] TERM = CNT_W'(DEBOUNCE_CYCLES - 1);

    deb_state_t       state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [KEY_W-1:0] cand, cand_next;
    logic             push;
    logic             armed;

    assign dbg_state = state;

    // A press already in progress at reset must be released before it can count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed <= 1'b0;
        end else if (!keypad_pressed) begin
            armed <= 1'b1;
        end
    end

    // Debounce state, counter and candidate key registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
            cand  <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            cand  <= cand_next;
        end
    end

    // Next-state logic; the counter saturates at TERM until the state changes.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        cand_next  = cand;
        push       = 1'b0;
        if (flush) begin
            state_next = keypad_pressed ? ST_HELD : ST_IDLE;
            cnt_next   = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (keypad_pressed && armed) begin
                        state_next = ST_PRESS_WAIT;
                        cand_next  = key;
                        cnt_next   = '0;
                    end
                end
                ST_PRESS_WAIT: begin
                    if (!keypad_pressed) begin
                        state_next = ST_IDLE;
                    end else if (key != cand) begin
                        cand_next = key;
                        cnt_next  = '0;
                    end else if (cnt == TERM) begin
                        push       = 1'b1;
                        state_next = ST_HELD;
                    end else begin
                        cnt_next = cnt + CNT_W'(1);
                    end
                end
                ST_HELD: begin
                    if (!keypad_pressed) begin
                        state_next = ST_RELEASE_WAIT;
                        cnt_next   = '0;
                    end
                end
                ST_RELEASE_WAIT: begin
                    if (keypad_pressed) begin
                        state_next = ST_HELD;
                    end else if (cnt == TERM) begin
                        state_next = ST_IDLE;
                    end else begin
                        cnt_next = cnt + CNT_W'(1);
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    key_event_buffer_fifo #(
        .DEPTH (DEPTH),
        .W     (KEY_W)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .din      (cand),
        .pop      (pop),
        .flush    (flush),
        .dout     (key_out),
        .valid    (key_valid),
        .count    (count),
        .overflow (overflow)
    );

endmodule
